// File: rtl/axi4_lite_mac_slave_if.sv
// AXI4-Lite slave bus bundle for the MAC register block; master drives requests, slave responds.
interface axi4_lite_mac_slave_if #(
  parameter int unsigned ADDRESS    = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  logic [ADDRESS-1:0]    S_AWADDR;
  logic                  S_AWVALID;
  logic                  S_AWREADY;
  logic [DATA_WIDTH-1:0] S_WDATA;
  logic [3:0]            S_WSTRB;
  logic                  S_WVALID;
  logic                  S_WREADY;
  logic [1:0]            S_BRESP;
  logic                  S_BVALID;
  logic                  S_BREADY;
  logic [ADDRESS-1:0]    S_ARADDR;
  logic                  S_ARVALID;
  logic                  S_ARREADY;
  logic [DATA_WIDTH-1:0] S_RDATA;
  logic [1:0]            S_RRESP;
  logic                  S_RVALID;
  logic                  S_RREADY;

  modport master (
    output S_AWADDR, S_AWVALID, S_WDATA, S_WSTRB, S_WVALID, S_BREADY,
    output S_ARADDR, S_ARVALID, S_RREADY,
    input  S_AWREADY, S_WREADY, S_BRESP, S_BVALID, S_ARREADY, S_RDATA, S_RRESP, S_RVALID
  );

  modport slave (
    input  S_AWADDR, S_AWVALID, S_WDATA, S_WSTRB, S_WVALID, S_BREADY,
    input  S_ARADDR, S_ARVALID, S_RREADY,
    output S_AWREADY, S_WREADY, S_BRESP, S_BVALID, S_ARREADY, S_RDATA, S_RRESP, S_RVALID
  );
endinterface

// File: rtl/axi4_lite_mac_slave.sv
// AXI4-Lite slave wrapping a 32x32 unsigned multiply-accumulate into a 64-bit accumulator.
// Define MAC_SATURATE_EN to clamp the accumulator on overflow instead of wrapping.
module axi4_lite_mac_slave #(
  parameter int unsigned ADDRESS    = 32,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  axi4_lite_mac_slave_if.slave  axi,
  output logic                  mac_done
);

  localparam int unsigned AccWidth = 2 * DATA_WIDTH;
  localparam logic [1:0]  RespOkay = 2'b00;
  localparam logic [1:0]  RespSlvErr = 2'b10;

  typedef enum logic [1:0] {WIdle, WAck, WResp} w_state_e;
  typedef enum logic [1:0] {RIdle, RAck, RData} r_state_e;

  w_state_e              w_state_q;
  r_state_e              r_state_q;
  logic                  awready_q;
  logic                  bvalid_q;
  logic [1:0]            bresp_q;
  logic                  arready_q;
  logic                  rvalid_q;
  logic [1:0]            rresp_q;
  logic [DATA_WIDTH-1:0] rdata_q;

  logic [DATA_WIDTH-1:0] opa_q;
  logic [DATA_WIDTH-1:0] opb_q;
  logic [AccWidth-1:0]   prod_q;
  logic [AccWidth-1:0]   acc_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  ovf_q;
  logic                  mac_done_q;

  logic [2:0]            waddr;
  logic [2:0]            raddr;
  logic                  w_req;
  logic                  w_bad;
  logic                  r_start;
  logic                  wr_en;
  logic                  ctrl_wr;
  logic                  ctrl_clr;
  logic                  ctrl_start;
  logic [AccWidth-1:0]   prod_d;
  logic [AccWidth:0]     sum;
  logic [DATA_WIDTH-1:0] rd_data;
  logic [1:0]            rd_resp;
  logic                  unused_addr;

  assign waddr = axi.S_AWADDR[4:2];
  assign raddr = axi.S_ARADDR[4:2];
  assign unused_addr = ^{axi.S_AWADDR[ADDRESS-1:5], axi.S_AWADDR[1:0],
                         axi.S_ARADDR[ADDRESS-1:5], axi.S_ARADDR[1:0]};

  assign w_req   = axi.S_AWVALID && axi.S_WVALID;
  assign w_bad   = (waddr[2:1] == 2'b11);
  // Reads wait for an idle write side so a simultaneous write always goes first.
  assign r_start = axi.S_ARVALID && (w_state_q == WIdle) && !w_req;

  assign wr_en      = (w_state_q == WAck);
  assign ctrl_wr    = wr_en && (waddr == 3'd0) && axi.S_WSTRB[0];
  assign ctrl_clr   = ctrl_wr && axi.S_WDATA[1];
  assign ctrl_start = ctrl_wr && axi.S_WDATA[0] && !axi.S_WDATA[1];

  assign prod_d = {{DATA_WIDTH{1'b0}}, opa_q} * {{DATA_WIDTH{1'b0}}, opb_q};
  assign sum    = {1'b0, acc_q} + {1'b0, prod_q};

  always_comb begin
    rd_data = '0;
    rd_resp = RespOkay;
    case (raddr)
      3'd0:    rd_data = '0;
      3'd1:    rd_data = opa_q;
      3'd2:    rd_data = opb_q;
      3'd3:    rd_data = {{(DATA_WIDTH-3){1'b0}}, ovf_q, done_q, busy_q};
      3'd4:    rd_data = acc_q[DATA_WIDTH-1:0];
      3'd5:    rd_data = acc_q[AccWidth-1:DATA_WIDTH];
      default: rd_resp = RespSlvErr;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      w_state_q <= WIdle;
      awready_q <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RespOkay;
    end else begin
      case (w_state_q)
        WIdle: begin
          if (w_req) begin
            w_state_q <= WAck;
            awready_q <= 1'b1;
          end
        end
        WAck: begin
          w_state_q <= WResp;
          awready_q <= 1'b0;
          bvalid_q  <= 1'b1;
          bresp_q   <= w_bad ? RespSlvErr : RespOkay;
        end
        WResp: begin
          if (axi.S_BREADY) begin
            w_state_q <= WIdle;
            bvalid_q  <= 1'b0;
            bresp_q   <= RespOkay;
          end
        end
        default: w_state_q <= WIdle;
      endcase
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_state_q <= RIdle;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rresp_q   <= RespOkay;
      rdata_q   <= '0;
    end else begin
      case (r_state_q)
        RIdle: begin
          if (r_start) begin
            r_state_q <= RAck;
            arready_q <= 1'b1;
          end
        end
        RAck: begin
          r_state_q <= RData;
          arready_q <= 1'b0;
          rvalid_q  <= 1'b1;
          rdata_q   <= rd_data;
          rresp_q   <= rd_resp;
        end
        RData: begin
          if (axi.S_RREADY) begin
            r_state_q <= RIdle;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= RespOkay;
          end
        end
        default: r_state_q <= RIdle;
      endcase
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      opa_q      <= '0;
      opb_q      <= '0;
      prod_q     <= '0;
      acc_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ovf_q      <= 1'b0;
      mac_done_q <= 1'b0;
    end else begin
      mac_done_q <= 1'b0;
      for (int b = 0; b < 4; b++) begin
        if (wr_en && axi.S_WSTRB[b] && (waddr == 3'd1)) opa_q[8*b +: 8] <= axi.S_WDATA[8*b +: 8];
        if (wr_en && axi.S_WSTRB[b] && (waddr == 3'd2)) opb_q[8*b +: 8] <= axi.S_WDATA[8*b +: 8];
      end
      if (busy_q) begin
        busy_q     <= 1'b0;
        done_q     <= 1'b1;
        mac_done_q <= 1'b1;
        if (sum[AccWidth]) begin
          ovf_q <= 1'b1;
`ifdef MAC_SATURATE_EN
          acc_q <= '1;
`else
          acc_q <= sum[AccWidth-1:0];
`endif
        end else begin
          acc_q <= sum[AccWidth-1:0];
        end
      end else if (ctrl_start) begin
        busy_q <= 1'b1;
        done_q <= 1'b0;
        prod_q <= prod_d;
      end
      // CLR has the last word over any accumulate landing on the same edge.
      if (ctrl_clr) begin
        acc_q  <= '0;
        done_q <= 1'b0;
        ovf_q  <= 1'b0;
      end
    end
  end

  assign axi.S_AWREADY = awready_q;
  assign axi.S_WREADY  = awready_q;
  assign axi.S_BVALID  = bvalid_q;
  assign axi.S_BRESP   = bresp_q;
  assign axi.S_ARREADY = arready_q;
  assign axi.S_RVALID  = rvalid_q;
  assign axi.S_RDATA   = rdata_q;
  assign axi.S_RRESP   = rresp_q;
  assign mac_done      = mac_done_q;

endmodule
